// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared window channel state encoding and travel default
package smart_home_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } win_state_t;

  localparam int DEFAULT_TRAVEL_CYCLES = 16;

endpackage

// File: rtl/window_axis.sv
// rtl/window_axis.sv - one window channel: travel FSM, position counter, status
// Obstruction auto-reverse is built only with WINDOW_OBSTRUCT_REVERSE_EN defined.
module window_axis
  import smart_home_pkg::*;
#(
  parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic close_req_i,
  input  logic open_req_i,
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
  input  logic obstruct_i,
`endif
  output logic win_state_o,
  output logic drive_close_o,
  output logic drive_open_o,
  output logic done_o
);

  localparam int PW = $clog2(TRAVEL_CYCLES + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(TRAVEL_CYCLES);

  win_state_t state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic win_state_q, done_q, done_d;
  logic close_eff;

`ifdef WINDOW_OBSTRUCT_REVERSE_EN
  // Set when an obstruction reversed the channel; close requests are ignored until OPEN.
  logic lock_q, lock_d;
  assign close_eff = close_req_i & ~lock_q;
`else
  assign close_eff = close_req_i;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      CLOSED: begin
        if (open_req_i && !close_req_i) state_d = OPENING;
      end
      OPENING: begin
        if (close_eff) begin
          state_d = CLOSING;
        end else begin
          if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
          if (pos_d == POS_MAX) begin
            state_d = OPEN;
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
            lock_d  = 1'b0;
`endif
          end
        end
      end
      OPEN: begin
        if (close_eff) state_d = CLOSING;
      end
      CLOSING: begin
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
        if (obstruct_i) begin
          state_d = OPENING;
          lock_d  = 1'b1;
        end else
`endif
        if (open_req_i && !close_req_i) begin
          state_d = OPENING;
        end else begin
          if (pos_q != '0) pos_d = pos_q - 1'b1;
          if (pos_d == '0) state_d = CLOSED;
        end
      end
      default: state_d = CLOSED;
    endcase
    done_d = ((state_q == OPENING) && (state_d == OPEN)) ||
             ((state_q == CLOSING) && (state_d == CLOSED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLOSED;
      pos_q       <= '0;
      win_state_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      win_state_q <= (pos_q != '0);
      done_q      <= done_d;
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign win_state_o   = win_state_q;
  assign drive_open_o  = (state_q == OPENING);
  assign drive_close_o = (state_q == CLOSING);
  assign done_o        = done_q;

endmodule

// File: rtl/window_actuator.sv
// rtl/window_actuator.sv - NUM_WIN independent window channels
// Obstruction auto-reverse is built only with WINDOW_OBSTRUCT_REVERSE_EN defined.
module window_actuator
  import smart_home_pkg::*;
#(
  parameter int NUM_WIN       = 8,
  parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WIN-1:0] motor_signal,
  input  logic [NUM_WIN-1:0] open_req,
  input  logic [NUM_WIN-1:0] obstruct,
  output logic [NUM_WIN-1:0] windowState,
  output logic [NUM_WIN-1:0] drive_close,
  output logic [NUM_WIN-1:0] drive_open,
  output logic [NUM_WIN-1:0] done
);

`ifndef WINDOW_OBSTRUCT_REVERSE_EN
  logic unused_obstruct;
  assign unused_obstruct = ^obstruct;
`endif

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_axis
    window_axis #(
      .TRAVEL_CYCLES(TRAVEL_CYCLES)
    ) u_axis (
      .clk          (clk),
      .rst          (rst),
      .close_req_i  (motor_signal[g]),
      .open_req_i   (open_req[g]),
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
      .obstruct_i   (obstruct[g]),
`endif
      .win_state_o  (windowState[g]),
      .drive_close_o(drive_close[g]),
      .drive_open_o (drive_open[g]),
      .done_o       (done[g])
    );
  end

endmodule

// File: tb/tb_window_actuator.sv
// tb/tb_window_actuator.sv - directed self-checking bench for window_actuator
module tb_window_actuator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] motor_signal = '0;
  logic [7:0] open_req = '0;
  logic [7:0] obstruct = '0;
  logic [7:0] windowState, drive_close, drive_open, done;
  int passed = 0;
  int total  = 0;

  window_actuator dut (
    .clk(clk), .rst(rst), .motor_signal(motor_signal), .open_req(open_req),
    .obstruct(obstruct), .windowState(windowState), .drive_close(drive_close),
    .drive_open(drive_open), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (windowState !== 8'h00) $display("FAIL reset_ws got %h exp 00", windowState); else passed++;
    total++; if (drive_open !== 8'h00) $display("FAIL reset_dopen got %h exp 00", drive_open); else passed++;
    total++; if (drive_close !== 8'h00) $display("FAIL reset_dclose got %h exp 00", drive_close); else passed++;
    total++; if (done !== 8'h00) $display("FAIL reset_done got %h exp 00", done); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_travel();
    open_req = 8'h01;
    tick();
    repeat (9) tick();
    total++; if (drive_open !== 8'h01) $display("FAIL mid_dopen got %h exp 01", drive_open); else passed++;
    total++; if (windowState !== 8'h01) $display("FAIL mid_ws got %h exp 01", windowState); else passed++;
    rst = 1'b1;
    tick();
    total++; if (windowState !== 8'h00) $display("FAIL mid_rst_ws got %h exp 00", windowState); else passed++;
    total++; if ((drive_open | drive_close) !== 8'h00) $display("FAIL mid_rst_drive got %h exp 00", drive_open | drive_close); else passed++;
    total++; if (done !== 8'h00) $display("FAIL mid_rst_done got %h exp 00", done); else passed++;
    rst = 1'b0;
    open_req = 8'h00;
    tick();
    total++; if (drive_open !== 8'h00) $display("FAIL mid_post_closed got %h exp 00", drive_open); else passed++;
  endtask

  task automatic test_full_open();
    int n_open = 0, n_done = 0, n_close = 0;
    open_req = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) open_req = 8'h00;
      if (drive_open[0]) n_open++;
      if (done[0]) n_done++;
      if (drive_close !== 8'h00) n_close++;
    end
    total++; if (n_open !== 16) $display("FAIL full_open_cycles got %0d exp 16", n_open); else passed++;
    total++; if (n_done !== 1) $display("FAIL full_open_done got %0d exp 1", n_done); else passed++;
    total++; if (n_close !== 0) $display("FAIL full_open_noclose got %0d exp 0", n_close); else passed++;
    total++; if (windowState !== 8'h01) $display("FAIL full_open_ws got %h exp 01", windowState); else passed++;
  endtask

  task automatic test_ignore_open();
    logic [7:0] act = '0;
    open_req = 8'h01;
    repeat (3) begin
      tick();
      act |= (drive_open & 8'h01) | (done & 8'h01);
    end
    open_req = 8'h00;
    total++; if (act !== 8'h00) $display("FAIL ignore_open got %h exp 00", act); else passed++;
  endtask

  task automatic test_priority();
    int n_close = 0, n_open = 0, n_done = 0;
    open_req = 8'hFF;
    tick();
    open_req = 8'h00;
    repeat (20) tick();
    total++; if (windowState !== 8'hFF) $display("FAIL prio_all_open_ws got %h exp ff", windowState); else passed++;
    motor_signal = 8'hFF;
    open_req = 8'hFF;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (drive_close === 8'hFF) n_close++;
      if (drive_open !== 8'h00) n_open++;
      if (done === 8'hFF) n_done++;
    end
    total++; if (n_close !== 16) $display("FAIL prio_close_cycles got %0d exp 16", n_close); else passed++;
    total++; if (n_open !== 0) $display("FAIL prio_open_cycles got %0d exp 0", n_open); else passed++;
    total++; if (n_done !== 1) $display("FAIL prio_done got %0d exp 1", n_done); else passed++;
    total++; if (windowState !== 8'h00) $display("FAIL prio_ws got %h exp 00", windowState); else passed++;
    motor_signal = 8'h00;
    open_req = 8'h00;
  endtask

  task automatic test_reversal();
    int n_close = 1, n_done = 0;
    open_req = 8'h04;
    tick();
    open_req = 8'h00;
    repeat (5) tick();
    motor_signal = 8'h04;
    tick();
    total++; if (drive_close !== 8'h04) $display("FAIL rev_dclose got %h exp 04", drive_close); else passed++;
    total++; if (drive_open !== 8'h00) $display("FAIL rev_dopen got %h exp 00", drive_open); else passed++;
    motor_signal = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (drive_close[2]) n_close++;
      if (done[2]) n_done++;
    end
    total++; if (n_close !== 5) $display("FAIL rev_close_cycles got %0d exp 5", n_close); else passed++;
    total++; if (n_done !== 1) $display("FAIL rev_done got %0d exp 1", n_done); else passed++;
    total++; if (windowState !== 8'h00) $display("FAIL rev_ws got %h exp 00", windowState); else passed++;
  endtask

  task automatic test_idle_close();
    logic [7:0] act = '0;
    motor_signal = 8'hAA;
    repeat (5) begin
      tick();
      act |= drive_open | drive_close | done;
    end
    motor_signal = 8'h00;
    total++; if (act !== 8'h00) $display("FAIL idle_activity got %h exp 00", act); else passed++;
    total++; if (windowState !== 8'h00) $display("FAIL idle_ws got %h exp 00", windowState); else passed++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    open_req = 8'h02;
    tick();
    open_req = 8'h00;
    repeat (20) tick();
    motor_signal = 8'h02;
    tick();
    motor_signal = 8'h00;
    repeat (3) tick();
    open_req = 8'h02;
    tick();
    open_req = 8'h00;
    total++; if (drive_open !== 8'h02) $display("FAIL b2b_dopen got %h exp 02", drive_open); else passed++;
    total++; if (drive_close !== 8'h00) $display("FAIL b2b_dclose got %h exp 00", drive_close); else passed++;
    while (n < 10 && done[1] !== 1'b1) begin
      tick();
      n++;
    end
    total++; if (n !== 3) $display("FAIL b2b_reopen_cycles got %0d exp 3", n); else passed++;
    total++; if (windowState !== 8'h02) $display("FAIL b2b_ws got %h exp 02", windowState); else passed++;
    motor_signal = 8'h02;
    tick();
    motor_signal = 8'h00;
    repeat (20) tick();
  endtask

`ifdef WINDOW_OBSTRUCT_REVERSE_EN
  task automatic test_obstruct();
    int n = 1;
    open_req = 8'h08;
    tick();
    open_req = 8'h00;
    repeat (20) tick();
    motor_signal = 8'h08;
    tick();
    repeat (8) tick();
    obstruct = 8'h08;
    tick();
    obstruct = 8'h00;
    total++; if (drive_open !== 8'h08) $display("FAIL obs_dopen got %h exp 08", drive_open); else passed++;
    while (n < 20 && done[3] !== 1'b1) begin
      tick();
      if (done[3] !== 1'b1) n++;
    end
    total++; if (n !== 8) $display("FAIL obs_open_cycles got %0d exp 8", n); else passed++;
    total++; if (windowState[3] !== 1'b1) $display("FAIL obs_ws got %b exp 1", windowState[3]); else passed++;
    motor_signal = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_travel();
    test_full_open();
    test_ignore_open();
    test_priority();
    test_reversal();
    test_idle_close();
    test_back_to_back();
`ifdef WINDOW_OBSTRUCT_REVERSE_EN
    test_obstruct();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
